// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and arbitration helper for mem_arbiter
package mem_arbiter_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RESP    = 3'd4
  } arb_state_e;

  // Round-robin pick: on contention the port that did not win last time goes next.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
    if (req == 2'b11) begin
      return ~last_gnt;
    end
    return req[1] ? PORT_DATA : PORT_FETCH;
  endfunction

  // One-hot vector for a port index.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_sync_2ff.sv
// rtl/mem_arbiter_sync_2ff.sv - generic 1-bit two-flop synchroniser
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two flops in series give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sequencing two requesters onto the async MEM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req,
  input  logic [1:0]    rw,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_mfc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e    state, state_nxt;
  logic          mfc_s;
  logic          owner;
  logic          last_gnt;
  logic          err_r;
  logic [CW-1:0] cnt;
  logic          timeout_hit;
  logic          win;

  sync_2ff u_mfc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mem_mfc),
    .q     (mfc_s)
  );

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign win         = rr_pick(req, last_gnt);

  // State register; reset returns to IDLE regardless of where the access was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: handshake sequencing with a timeout escape from STROBE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|req) state_nxt = ST_SETUP;
      ST_SETUP:   state_nxt = ST_STROBE;
      ST_STROBE:  if (mfc_s || timeout_hit) state_nxt = ST_RELEASE;
      ST_RELEASE: if (err_r || !mfc_s) state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath; bus fields are frozen from grant until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= 2'b00;
      done      <= 2'b00;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_rw    <= RW_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= PORT_FETCH;
      last_gnt  <= PORT_DATA;
      err_r     <= 1'b0;
      cnt       <= '0;
    end else begin
      mem_en <= (state_nxt == ST_STROBE);
      done   <= 2'b00;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            owner     <= win;
            gnt       <= port_onehot(win);
            mem_addr  <= (win == PORT_DATA) ? addr1 : addr0;
            mem_wdata <= (win == PORT_DATA) ? wdata1 : wdata0;
            mem_rw    <= rw[win];
          end
        end
        ST_SETUP: begin
          cnt <= '0;
        end
        ST_STROBE: begin
          cnt <= cnt + 1'b1;
          if (mfc_s) begin
            if (mem_rw == RW_READ) rdata <= mem_rdata;
          end else if (timeout_hit) begin
            err_r <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (state_nxt == ST_RESP) begin
            done <= port_onehot(owner);
            err  <= err_r;
          end
        end
        ST_RESP: begin
          last_gnt <= owner;
          gnt      <= 2'b00;
          err_r    <= 1'b0;
        end
        default: begin
          gnt <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural MEM
module tb_mem_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int BUDGET  = 300;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [1:0]    rw;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic          err;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_mfc;

  int n_checks;
  int n_errors;

  logic [DW-1:0] mem_model [0:255];
  logic          mfc_stuck;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rw        (rw),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_mfc   (mem_mfc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MEM: acts on EN rise, raises MFC 5 ns later, drops it 5 ns after EN falls.
  always @(posedge mem_en) begin
    #5;
    if (!mfc_stuck && mem_en) begin
      if (mem_rw) mem_rdata = mem_model[mem_addr[7:0]];
      else        mem_model[mem_addr[7:0]] = mem_wdata;
      mem_mfc = 1'b1;
    end
  end

  always @(negedge mem_en) begin
    #5;
    mem_mfc = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Single-port access; returns what was seen on the done cycle and counts EN-high cycles.
  task automatic run_access(input string tag, input logic port, input logic dir,
                            input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic [1:0] done_o, output logic err_o,
                            output logic [DW-1:0] rdata_o, output int en_cycles);
    logic seen;
    seen      = 1'b0;
    en_cycles = 0;
    if (port) begin addr1 = a; wdata1 = d; end
    else      begin addr0 = a; wdata0 = d; end
    rw[port]  = dir;
    req[port] = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (mem_en) en_cycles++;
      if (done != 2'b00) begin seen = 1'b1; break; end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    done_o    = done;
    err_o     = err;
    rdata_o   = rdata;
    req[port] = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  logic [1:0]    d_o;
  logic          e_o;
  logic [DW-1:0] r_o;
  int            en_c;
  logic          seen_l;
  logic          bad;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    for (int i = 0; i < 256; i++) mem_model[i] = 16'h0000;
    mem_model[0] = 16'h7002;
    mem_model[1] = 16'hF0FF;
    mem_model[2] = 16'h1043;
    mfc_stuck = 1'b0;
    mem_mfc   = 1'b0;
    mem_rdata = 16'h0000;
    rst_n  = 1'b0;
    req    = 2'b00;
    rw     = 2'b11;
    addr0  = '0;
    addr1  = '0;
    wdata0 = '0;
    wdata1 = '0;
    repeat (3) @(negedge clk);

    check("rst_gnt",   32'(gnt),      32'd0);
    check("rst_done",  32'(done),     32'd0);
    check("rst_err",   32'(err),      32'd0);
    check("rst_rdata", 32'(rdata),    32'd0);
    check("rst_en",    32'(mem_en),   32'd0);
    check("rst_rw",    32'(mem_rw),   32'd1);
    check("rst_addr",  32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 read of 0x0002
    run_access("t2", 1'b0, 1'b1, 16'h0002, 16'h0000, d_o, e_o, r_o, en_c);
    check("t2_done",  32'(d_o), 32'h1);
    check("t2_err",   32'(e_o), 32'h0);
    check("t2_rdata", 32'(r_o), 32'h1043);
    check("t2_en",    32'(en_c >= 1), 32'd1);

    // Reset in the middle of a port 1 strobe; port 0 last won so port 1 would be next
    addr1  = 16'h0001;
    rw[1]  = 1'b1;
    req[1] = 1'b1;
    seen_l = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (mem_en) begin seen_l = 1'b1; break; end
    end
    check("t1_strobe", 32'(seen_l), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_en_async", 32'(mem_en), 32'd0);
    check("t1_gnt",      32'(gnt),    32'd0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done != 2'b00) bad = 1'b1;
    end
    check("t1_no_done", 32'(bad), 32'd0);

    // Both ports request continuously after reset: port 0 first, then alternate
    addr0 = 16'h0000;
    addr1 = 16'h0001;
    rw    = 2'b11;
    req   = 2'b11;
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_first_gnt", 32'(gnt), 32'h1);
    for (int k = 0; k < 4; k++) begin
      seen_l = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
        if (done != 2'b00) begin seen_l = 1'b1; break; end
        @(negedge clk);
      end
      check("t4_seen", 32'(seen_l), 32'd1);
      check("t4_done", 32'(done), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t4_rdata", 32'(rdata), (k % 2 == 0) ? 32'h7002 : 32'hF0FF);
      if (k == 3) req = 2'b00;
      @(negedge clk);
    end
    @(negedge clk);

    // Port 1 write then read back
    run_access("t3w", 1'b1, 1'b0, 16'h0010, 16'h00AA, d_o, e_o, r_o, en_c);
    check("t3w_done", 32'(d_o), 32'h2);
    check("t3w_err",  32'(e_o), 32'h0);
    check("t3w_mem",  32'(mem_model[16]), 32'h00AA);
    run_access("t3r", 1'b1, 1'b1, 16'h0010, 16'h0000, d_o, e_o, r_o, en_c);
    check("t3r_done",  32'(d_o), 32'h2);
    check("t3r_rdata", 32'(r_o), 32'h00AA);

    // MFC never answers: timeout abort after exactly TIMEOUT strobe cycles
    mfc_stuck = 1'b1;
    run_access("t5", 1'b0, 1'b1, 16'h0002, 16'h0000, d_o, e_o, r_o, en_c);
    check("t5_done",  32'(d_o), 32'h1);
    check("t5_err",   32'(e_o), 32'h1);
    check("t5_rdata", 32'(r_o), 32'h00AA);
    check("t5_en_cycles", 32'(en_c), 32'(TIMEOUT));
    mfc_stuck = 1'b0;
    @(negedge clk);
    check("t5_err_clear", 32'(err), 32'd0);

    // Requester moves addr0 after grant; MEM address must stay at the captured value
    addr0  = 16'h0000;
    rw[0]  = 1'b1;
    req[0] = 1'b1;
    seen_l = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (gnt[0]) begin seen_l = 1'b1; break; end
    end
    check("t6_gnt", 32'(seen_l), 32'd1);
    addr0  = 16'h00FF;
    bad    = 1'b0;
    seen_l = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (mem_addr !== 16'h0000) bad = 1'b1;
      if (done != 2'b00) begin seen_l = 1'b1; break; end
      @(negedge clk);
    end
    check("t6_seen",   32'(seen_l), 32'd1);
    check("t6_frozen", 32'(bad), 32'd0);
    check("t6_rdata",  32'(rdata), 32'h7002);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
